// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU-side memory block.
//   mem_state_t    : port-arbitration FSM states
//   MEM_ADDR_W     : byte address width
//   MEM_DATA_W     : word width
//   MEM_WORD_IDX_W : word index width (addr[13:2])
package mem_pkg;

    localparam int unsigned MEM_ADDR_W     = 14;
    localparam int unsigned MEM_DATA_W     = 32;
    localparam int unsigned MEM_WORD_IDX_W = 12;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StHostAccess,
        StRestore
    } mem_state_t;

    // Word accesses only; the low two address bits must be zero.
    function automatic logic is_misaligned(input logic [MEM_ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/cpu_mem_if.sv
// Bus bundle between cpu_mem and its requesters (CPU core and host bridge).
// Signal directions in the names are from cpu_mem's point of view.
//   CPU  : i_mem_write_en, i_mem_addr, i_mem_data, o_mem_data, o_cpu_enable
//   Host : i_host_valid/o_host_ready request, i_host_write, i_host_addr,
//          i_host_wdata, o_host_rvalid/o_host_rdata completion
//   Status: o_misaligned
// Modports: slave = cpu_mem, master = requester side.
interface cpu_mem_if;
    import mem_pkg::*;

    logic                  i_mem_write_en;
    logic [MEM_ADDR_W-1:0] i_mem_addr;
    logic [MEM_DATA_W-1:0] i_mem_data;
    logic [MEM_DATA_W-1:0] o_mem_data;
    logic                  o_cpu_enable;

    logic                  i_host_valid;
    logic                  o_host_ready;
    logic                  i_host_write;
    logic [MEM_ADDR_W-1:0] i_host_addr;
    logic [MEM_DATA_W-1:0] i_host_wdata;
    logic                  o_host_rvalid;
    logic [MEM_DATA_W-1:0] o_host_rdata;

    logic                  o_misaligned;

    modport slave (
        input  i_mem_write_en, i_mem_addr, i_mem_data,
        output o_mem_data, o_cpu_enable,
        input  i_host_valid, i_host_write, i_host_addr, i_host_wdata,
        output o_host_ready, o_host_rvalid, o_host_rdata,
        output o_misaligned
    );

    modport master (
        output i_mem_write_en, i_mem_addr, i_mem_data,
        input  o_mem_data, o_cpu_enable,
        output i_host_valid, i_host_write, i_host_addr, i_host_wdata,
        input  o_host_ready, o_host_rvalid, o_host_rdata,
        input  o_misaligned
    );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, read-first, registered read data.
//   i_clk, i_rst : clock, async active-high reset (read register only)
//   i_we         : write enable
//   i_addr       : word index
//   i_wdata      : write data
//   o_rdata      : registered read data (old contents on a same-edge write)
module mem_array #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/cpu_mem.sv
// CPU data memory with a host port that borrows the single RAM port by
// stalling the CPU through o_cpu_enable.
//   i_clk, i_rst : clock, async active-high reset
//   bus          : cpu_mem_if slave (CPU bus, host request/completion, misaligned flag)
module cpu_mem
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    cpu_mem_if.slave   bus
);

    mem_state_t state_q, state_d;

    logic                      host_ready;
    logic                      host_accept;
    logic                      ram_we;
    logic [MEM_WORD_IDX_W-1:0] ram_addr;
    logic [MEM_DATA_W-1:0]     ram_wdata;
    logic [MEM_DATA_W-1:0]     ram_rdata;

    logic                      cpu_enable_q;
    logic                      host_rvalid_q;
    logic                      misaligned_q;
    logic                      host_write_q;
    logic [MEM_ADDR_W-1:0]     host_addr_q;
    logic [MEM_DATA_W-1:0]     host_wdata_q;
    logic [MEM_DATA_W-1:0]     cpu_hold_q;
    logic [MEM_DATA_W-1:0]     host_rdata_q;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:       state_d = StIdle;
            StIdle:       if (host_accept) state_d = StHostAccess;
            StHostAccess: state_d = StRestore;
            StRestore:    state_d = StIdle;
            default:      state_d = StInit;
        endcase
    end

    // Outputs / port mux
    always_comb begin
        host_ready = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = bus.i_mem_addr[MEM_ADDR_W-1:2];
        ram_wdata  = bus.i_mem_data;
        unique case (state_q)
            StIdle: begin
                host_ready = 1'b1;
                ram_we     = bus.i_mem_write_en;
            end
            StHostAccess: begin
                ram_we    = host_write_q;
                ram_addr  = host_addr_q[MEM_ADDR_W-1:2];
                ram_wdata = host_wdata_q;
            end
            default: ;
        endcase
    end

    assign host_accept = bus.i_host_valid & host_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cpu_enable_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            host_write_q  <= 1'b0;
            host_addr_q   <= '0;
            host_wdata_q  <= '0;
            cpu_hold_q    <= '0;
            host_rdata_q  <= '0;
        end else begin
            cpu_enable_q  <= (state_d == StIdle);
            host_rvalid_q <= (state_q == StHostAccess);
            if (host_accept) begin
                host_write_q <= bus.i_host_write;
                host_addr_q  <= bus.i_host_addr;
                host_wdata_q <= bus.i_host_wdata;
            end
            if ((host_accept && is_misaligned(bus.i_host_addr)) ||
                (state_q == StIdle && bus.i_mem_write_en && is_misaligned(bus.i_mem_addr))) begin
                misaligned_q <= 1'b1;
            end
            // RAM output still carries the CPU word at the host-access edge.
            if (state_q == StHostAccess) begin
                cpu_hold_q <= ram_rdata;
            end
            if (state_q == StRestore) begin
                host_rdata_q <= ram_rdata;
            end
        end
    end

    // In RESTORE the RAM register holds the host word, so the CPU sees its held copy.
    assign bus.o_mem_data    = (state_q == StRestore) ? cpu_hold_q : ram_rdata;
    assign bus.o_host_rdata  = (state_q == StRestore) ? ram_rdata : host_rdata_q;
    assign bus.o_host_ready  = host_ready;
    assign bus.o_cpu_enable  = cpu_enable_q;
    assign bus.o_host_rvalid = host_rvalid_q;
    assign bus.o_misaligned  = misaligned_q;

    mem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (MEM_WORD_IDX_W),
        .DW    (MEM_DATA_W)
    ) u_mem_array (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (ram_we),
        .i_addr  (ram_addr),
        .i_wdata (ram_wdata),
        .o_rdata (ram_rdata)
    );

endmodule

// File: tb/tb_cpu_mem.sv
// Directed self-checking bench for cpu_mem.
module tb_cpu_mem;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   accept_cyc;

    cpu_mem_if bus ();

    cpu_mem #(
        .DEPTH_WORDS (4096)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    // Issue one host request; called at a negedge, returns #1 after the accepting edge.
    task automatic host_go(input logic wr, input logic [13:0] a, input logic [31:0] d);
        int n;
        bus.i_host_valid = 1'b1;
        bus.i_host_write = wr;
        bus.i_host_addr  = a;
        bus.i_host_wdata = d;
        n = 0;
        while (!bus.o_host_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL host_accept_timeout: ready=%0b required 1 within 20 cycles",
                     bus.o_host_ready);
        end
        @(posedge clk);
        accept_cyc = cyc;
        #1;
        bus.i_host_valid = 1'b0;
        bus.i_host_write = 1'b0;
        bus.i_host_addr  = 14'h3ffc;
        bus.i_host_wdata = 32'hbad0bad0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.o_cpu_enable !== 1'b0) begin bad++;
            $display("FAIL rst_enable: got %b required 0", bus.o_cpu_enable); end
        total++; if (bus.o_host_ready !== 1'b0) begin bad++;
            $display("FAIL rst_ready: got %b required 0", bus.o_host_ready); end
        total++; if (bus.o_host_rvalid !== 1'b0) begin bad++;
            $display("FAIL rst_rvalid: got %b required 0", bus.o_host_rvalid); end
        total++; if (bus.o_host_rdata !== 32'h0) begin bad++;
            $display("FAIL rst_rdata: got %h required 0", bus.o_host_rdata); end
        total++; if (bus.o_mem_data !== 32'h0) begin bad++;
            $display("FAIL rst_mem_data: got %h required 0", bus.o_mem_data); end
        total++; if (bus.o_misaligned !== 1'b0) begin bad++;
            $display("FAIL rst_misaligned: got %b required 0", bus.o_misaligned); end
        rst = 1'b0;
        #1;
        total++; if (bus.o_cpu_enable !== 1'b0 || bus.o_host_ready !== 1'b0) begin bad++;
            $display("FAIL init_state: enable=%b ready=%b required 0 0",
                     bus.o_cpu_enable, bus.o_host_ready); end
        @(negedge clk);
        total++; if (bus.o_cpu_enable !== 1'b1 || bus.o_host_ready !== 1'b1) begin bad++;
            $display("FAIL first_idle: enable=%b ready=%b required 1 1",
                     bus.o_cpu_enable, bus.o_host_ready); end
    endtask

    task automatic test_host_write_read();
        host_go(1'b1, 14'h0010, 32'hdeadbeef);
        @(negedge clk);
        total++; if (bus.o_cpu_enable !== 1'b0 || bus.o_host_rvalid !== 1'b0 ||
                     bus.o_host_ready !== 1'b0) begin bad++;
            $display("FAIL wr_host_access: enable=%b rvalid=%b ready=%b required 0 0 0",
                     bus.o_cpu_enable, bus.o_host_rvalid, bus.o_host_ready); end
        @(negedge clk);
        total++; if (bus.o_host_rvalid !== 1'b1) begin bad++;
            $display("FAIL wr_rvalid: got %b required 1", bus.o_host_rvalid); end
        @(negedge clk);
        total++; if (bus.o_host_rvalid !== 1'b0 || bus.o_cpu_enable !== 1'b1) begin bad++;
            $display("FAIL wr_done: rvalid=%b enable=%b required 0 1",
                     bus.o_host_rvalid, bus.o_cpu_enable); end
        host_go(1'b0, 14'h0010, 32'h0);
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.o_host_rvalid !== 1'b1 || bus.o_host_rdata !== 32'hdeadbeef) begin bad++;
            $display("FAIL rd_back: rvalid=%b rdata=%h required 1 deadbeef",
                     bus.o_host_rvalid, bus.o_host_rdata); end
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        for (int i = 0; i < 4; i++) begin
            host_go(1'b1, 14'(i * 4), 32'ha0000000 + 32'(i));
            repeat (3) @(negedge clk);
        end
        bus.i_mem_addr = 14'h0008;
        @(negedge clk);
        total++; if (bus.o_mem_data !== 32'ha0000002) begin bad++;
            $display("FAIL cpu_read_w2: got %h required a0000002", bus.o_mem_data); end
        bus.i_mem_addr = 14'h0000;
        @(negedge clk);
        total++; if (bus.o_mem_data !== 32'ha0000000) begin bad++;
            $display("FAIL cpu_read_w0: got %h required a0000000", bus.o_mem_data); end
    endtask

    task automatic test_stall();
        int low;
        bus.i_mem_addr = 14'h0004;
        @(negedge clk);
        total++; if (bus.o_mem_data !== 32'ha0000001) begin bad++;
            $display("FAIL stall_pre: got %h required a0000001", bus.o_mem_data); end
        host_go(1'b0, 14'h000c, 32'h0);
        low = 0;
        @(negedge clk);
        if (!bus.o_cpu_enable) low++;
        total++; if (bus.o_mem_data !== 32'ha0000001) begin bad++;
            $display("FAIL stall_hold_ha: got %h required a0000001", bus.o_mem_data); end
        @(negedge clk);
        if (!bus.o_cpu_enable) low++;
        total++; if (bus.o_host_rdata !== 32'ha0000003 || bus.o_mem_data !== 32'ha0000001)
            begin bad++;
            $display("FAIL stall_restore: rdata=%h mem_data=%h required a0000003 a0000001",
                     bus.o_host_rdata, bus.o_mem_data); end
        @(negedge clk);
        if (!bus.o_cpu_enable) low++;
        total++; if (bus.o_cpu_enable !== 1'b1 || bus.o_mem_data !== 32'ha0000001) begin bad++;
            $display("FAIL stall_reenable: enable=%b mem_data=%h required 1 a0000001",
                     bus.o_cpu_enable, bus.o_mem_data); end
        @(negedge clk);
        if (!bus.o_cpu_enable) low++;
        total++; if (low !== 2) begin bad++;
            $display("FAIL stall_cycles: got %0d required 2", low); end
    endtask

    task automatic test_same_edge();
        bus.i_mem_write_en = 1'b1;
        bus.i_mem_addr     = 14'h0020;
        bus.i_mem_data     = 32'h11111111;
        host_go(1'b0, 14'h0020, 32'h0);
        bus.i_mem_write_en = 1'b0;
        bus.i_mem_data     = 32'h0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.o_host_rvalid !== 1'b1 || bus.o_host_rdata !== 32'h11111111) begin bad++;
            $display("FAIL same_edge_host: rvalid=%b rdata=%h required 1 11111111",
                     bus.o_host_rvalid, bus.o_host_rdata); end
        @(negedge clk);
        total++; if (bus.o_mem_data !== 32'h11111111) begin bad++;
            $display("FAIL same_edge_cpu: got %h required 11111111", bus.o_mem_data); end
    endtask

    task automatic test_back_to_back();
        int first;
        bus.i_mem_addr = 14'h0000;
        host_go(1'b0, 14'h0000, 32'h0);
        first = accept_cyc;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.o_host_rdata !== 32'ha0000000) begin bad++;
            $display("FAIL b2b_first: got %h required a0000000", bus.o_host_rdata); end
        @(negedge clk);
        total++; if (bus.o_cpu_enable !== 1'b1 || bus.o_host_ready !== 1'b1) begin bad++;
            $display("FAIL b2b_gap: enable=%b ready=%b required 1 1",
                     bus.o_cpu_enable, bus.o_host_ready); end
        host_go(1'b0, 14'h0004, 32'h0);
        total++; if (accept_cyc - first !== 3) begin bad++;
            $display("FAIL b2b_spacing: got %0d required 3", accept_cyc - first); end
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.o_host_rdata !== 32'ha0000001) begin bad++;
            $display("FAIL b2b_second: got %h required a0000001", bus.o_host_rdata); end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        total++; if (bus.o_misaligned !== 1'b0) begin bad++;
            $display("FAIL mis_pre: got %b required 0", bus.o_misaligned); end
        host_go(1'b0, 14'h0013, 32'h0);
        @(negedge clk);
        total++; if (bus.o_misaligned !== 1'b1) begin bad++;
            $display("FAIL mis_set: got %b required 1", bus.o_misaligned); end
        @(negedge clk);
        total++; if (bus.o_host_rdata !== 32'hdeadbeef) begin bad++;
            $display("FAIL mis_word4: got %h required deadbeef", bus.o_host_rdata); end
        repeat (4) @(negedge clk);
        total++; if (bus.o_misaligned !== 1'b1) begin bad++;
            $display("FAIL mis_sticky: got %b required 1", bus.o_misaligned); end
        // Reset lands while the host write is in HOST_ACCESS, before it is performed.
        host_go(1'b1, 14'h0010, 32'h55555555);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (bus.o_misaligned !== 1'b0 || bus.o_cpu_enable !== 1'b0) begin bad++;
            $display("FAIL mid_rst_clear: misaligned=%b enable=%b required 0 0",
                     bus.o_misaligned, bus.o_cpu_enable); end
        @(negedge clk);
        total++; if (bus.o_host_rvalid !== 1'b0) begin bad++;
            $display("FAIL mid_rst_rvalid1: got %b required 0", bus.o_host_rvalid); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.o_host_rvalid !== 1'b0) begin bad++;
            $display("FAIL mid_rst_rvalid2: got %b required 0", bus.o_host_rvalid); end
        host_go(1'b0, 14'h0010, 32'h0);
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.o_host_rdata !== 32'hdeadbeef) begin bad++;
            $display("FAIL mid_rst_write_lost: got %h required deadbeef", bus.o_host_rdata); end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        accept_cyc = 0;
        rst = 1'b1;
        bus.i_mem_write_en = 1'b0;
        bus.i_mem_addr     = 14'h0;
        bus.i_mem_data     = 32'h0;
        bus.i_host_valid   = 1'b0;
        bus.i_host_write   = 1'b0;
        bus.i_host_addr    = 14'h0;
        bus.i_host_wdata   = 32'h0;
        test_reset();
        test_host_write_read();
        test_cpu_read();
        test_stall();
        test_same_edge();
        test_back_to_back();
        test_misaligned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
